tm_sequencer: RTL and testbench
===============================

TM_SEQUENCER -- requirements
Module: tm_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_DEPTH, default 64, meaning the number of 4-bit program words held.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 3, meaning the cycles tm_input_data is stable before tm_next rises.
REQ-003 The block SHALL have parameter PULSE_CYCLES, default 2, meaning the high width of tm_next and tm_done.
REQ-004 The block SHALL have parameter GAP_CYCLES, default 2, meaning the low cycles after each pulse.
REQ-005 The block SHALL have parameter STEP_INTERVAL, default 5, meaning the idle cycles between auto-run steps.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  $clog2(PROG_DEPTH)  program write address.
- prog_data  in  4  program word.
- prog_len  in  $clog2(PROG_DEPTH)+1  number of words to load; sampled on start.
- start  in  1  begin load-then-run.
- auto_run  in  1  1 = step every STEP_INTERVAL; 0 = step on step_req.
- step_req  in  1  single-step request.
- compute_done  in  1  halt indication from the Turing machine.
- tm_input_data  out  4  word to the Turing machine.
- tm_next  out  1  Next pulse to the Turing machine.
- tm_done  out  1  Done pulse to the Turing machine.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- step_count  out  16  steps issued since start.

Function
REQ-007 FSM states SHALL be IDLE, LD_SETUP, LD_PULSE, LD_GAP, FIN_PULSE, FIN_GAP, RUN_WAIT, RUN_PULSE, RUN_GAP, HALT.
REQ-008 A prog_we in IDLE or HALT SHALL write prog_data to prog_addr at the clock edge; prog_we in any other state SHALL be ignored.
REQ-009 start in IDLE or HALT SHALL latch prog_len, clear the word index and step_count, and enter LD_SETUP (or FIN_PULSE if prog_len==0); start in any other state SHALL be ignored.
REQ-010 LD_SETUP SHALL drive tm_input_data=word[index] for HOLD_CYCLES cycles, then enter LD_PULSE.
REQ-011 LD_PULSE SHALL hold tm_next=1 for PULSE_CYCLES cycles with tm_input_data unchanged, then enter LD_GAP.
REQ-012 LD_GAP SHALL hold tm_next=0 for GAP_CYCLES cycles, increment index, then enter LD_SETUP if index<prog_len, else FIN_PULSE.
REQ-013 FIN_PULSE SHALL hold tm_done=1 for PULSE_CYCLES cycles; FIN_GAP SHALL hold tm_done=0 for GAP_CYCLES cycles, then enter RUN_WAIT.
REQ-014 RUN_WAIT SHALL enter HALT if compute_done=1; else enter RUN_PULSE after STEP_INTERVAL cycles (auto_run=1) or on the cycle after step_req=1 (auto_run=0).
REQ-015 RUN_PULSE SHALL hold tm_next=1 for PULSE_CYCLES cycles and increment step_count once on entry; RUN_GAP SHALL hold tm_next=0 for GAP_CYCLES cycles, then return to RUN_WAIT.
REQ-016 step_req outside RUN_WAIT SHALL be dropped, not queued.
REQ-017 step_count SHALL saturate at 16'hFFFF.
REQ-018 tm_input_data SHALL hold its last value outside LD_* states; tm_next and tm_done SHALL never be high together.
REQ-019 prog_len greater than PROG_DEPTH SHALL be clamped to PROG_DEPTH.

Reset
REQ-020 Reset=1 SHALL asynchronously force IDLE, tm_input_data=0, tm_next=0, tm_done=0, busy=0, halted=0, step_count=0, mid-operation included; program memory contents are unspecified after reset.

Configuration
REQ-021 With TM_SEQ_STEP_LIMIT_EN defined, parameter MAX_STEPS (default 1024) and output timeout (1 bit, reset 0) SHALL exist; RUN_WAIT with step_count==MAX_STEPS SHALL enter HALT with timeout=1, cleared on start.
REQ-022 Without TM_SEQ_STEP_LIMIT_EN, neither MAX_STEPS nor timeout SHALL exist and the run SHALL end only on compute_done.

Verification
REQ-023 Write words 3,1,1,2 at 0..3, prog_len=4, start -> four tm_next pulses, each 2 cycles high, preceded by 3 stable-data cycles and followed by 2 low; then one 2-cycle tm_done pulse.
REQ-024 prog_len=0, start -> no tm_next during load; tm_done pulse within 2 cycles; RUN_WAIT reached.
REQ-025 auto_run=1, compute_done asserted after 10 steps -> step_count=10, halted=1, busy=0.
REQ-026 auto_run=0, step_req pulsed during RUN_PULSE and again in RUN_WAIT -> exactly one extra step, step_count increments by 1.
REQ-027 Reset asserted during LD_PULSE -> tm_next=0 with no clock edge; IDLE; restart reloads from word 0.
REQ-028 TM_SEQ_STEP_LIMIT_EN, MAX_STEPS=8, compute_done held 0 -> halted=1, timeout=1, step_count=8.

Source files
------------

// File: rtl/tm_sequencer.sv
// -----------------------------------------------------------------------------
// tm_sequencer
//
// Feeds a stored program of 4-bit words into a Turing machine, one word per
// Next handshake, then signals end-of-load with a Done pulse and afterwards
// clocks the machine with Next pulses, either automatically every
// STEP_INTERVAL cycles or on a single-step request, until the machine reports
// that it has halted.
//
// Optional feature (macro TM_SEQ_STEP_LIMIT_EN):
//   Adds parameter MAX_STEPS and output timeout. The run is aborted into HALT
//   with timeout=1 once step_count reaches MAX_STEPS. Without the macro the
//   run ends only on compute_done.
//
// Ports
//   clock          in   rising-edge clock
//   Reset          in   asynchronous active-high reset
//   prog_we        in   program write strobe (honoured only in IDLE/HALT)
//   prog_addr      in   program write address
//   prog_data      in   4-bit program word
//   prog_len       in   words to load, sampled on start, clamped to PROG_DEPTH
//   start          in   begin load-then-run (honoured only in IDLE/HALT)
//   auto_run       in   1 = free-running steps, 0 = step on step_req
//   step_req       in   single-step request (only seen while waiting)
//   compute_done   in   halt indication from the Turing machine
//   tm_input_data  out  word presented to the Turing machine
//   tm_next        out  Next pulse
//   tm_done        out  Done pulse (end of program load)
//   busy           out  high in every state except IDLE and HALT
//   halted         out  high in HALT
//   step_count     out  run steps issued since start, saturating
//   timeout        out  (TM_SEQ_STEP_LIMIT_EN only) step limit reached
// -----------------------------------------------------------------------------
module tm_sequencer #(
  parameter int PROG_DEPTH    = 64,
  parameter int HOLD_CYCLES   = 3,
  parameter int PULSE_CYCLES  = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int STEP_INTERVAL = 5
`ifdef TM_SEQ_STEP_LIMIT_EN
  ,
  parameter int MAX_STEPS     = 1024
`endif
) (
  input  logic                          clock,
  input  logic                          Reset,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [3:0]                    prog_data,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic                          start,
  input  logic                          auto_run,
  input  logic                          step_req,
  input  logic                          compute_done,
  output logic [3:0]                    tm_input_data,
  output logic                          tm_next,
  output logic                          tm_done,
  output logic                          busy,
  output logic                          halted,
  output logic [15:0]                   step_count
`ifdef TM_SEQ_STEP_LIMIT_EN
  ,
  output logic                          timeout
`endif
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int LW = AW + 1;

  // Down-counter reload values: a phase of N cycles loads N-1 and leaves
  // when the counter reads zero.
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] STEP_LD  = 16'(STEP_INTERVAL - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(PROG_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    LD_SETUP,
    LD_PULSE,
    LD_GAP,
    FIN_PULSE,
    FIN_GAP,
    RUN_WAIT,
    RUN_PULSE,
    RUN_GAP,
    HALT
  } state_t;

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic [LW-1:0]   r_idx;
  logic [LW-1:0]   r_len;
  logic [3:0]      r_data;
  logic            r_next;
  logic            r_done;
  logic            r_busy;
  logic            r_halted;
  logic [15:0]     r_steps;
`ifdef TM_SEQ_STEP_LIMIT_EN
  logic            r_timeout;
`endif

  // Program store; contents are deliberately left out of reset.
  logic [3:0]      r_mem [PROG_DEPTH];

  logic            w_idle_like;
  logic [LW-1:0]   w_len_clamped;
  logic [LW-1:0]   w_idx_nxt;
  logic [AW-1:0]   w_rd_addr_nxt;
  logic [15:0]     w_steps_inc;

  assign w_idle_like   = (r_state == IDLE) || (r_state == HALT);
  assign w_len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_idx_nxt     = r_idx + LW'(1);
  // Only used when w_idx_nxt < r_len <= PROG_DEPTH, so truncation is safe.
  assign w_rd_addr_nxt = w_idx_nxt[AW-1:0];
  assign w_steps_inc   = (r_steps == 16'hFFFF) ? r_steps : r_steps + 16'd1;

  assign tm_input_data = r_data;
  assign tm_next       = r_next;
  assign tm_done       = r_done;
  assign busy          = r_busy;
  assign halted        = r_halted;
  assign step_count    = r_steps;
`ifdef TM_SEQ_STEP_LIMIT_EN
  assign timeout       = r_timeout;
`endif

  // Program writes are accepted only while the sequencer is not using the
  // store, so a load in progress always sees a stable program.
  always_ff @(posedge clock) begin
    if (prog_we && w_idle_like) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM. Every output is registered and updated on the same edge
  // as the state change, so each output level lines up exactly with the
  // state it belongs to (tm_next high exactly in LD_PULSE/RUN_PULSE,
  // tm_done high exactly in FIN_PULSE).
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_next    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_steps   <= '0;
`ifdef TM_SEQ_STEP_LIMIT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_len    <= w_len_clamped;
            r_idx    <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
`ifdef TM_SEQ_STEP_LIMIT_EN
            r_timeout <= 1'b0;
`endif
            if (w_len_clamped == '0) begin
              // Empty program: go straight to the end-of-load pulse.
              r_state <= FIN_PULSE;
              r_done  <= 1'b1;
              r_cnt   <= PULSE_LD;
            end else begin
              r_state <= LD_SETUP;
              r_data  <= r_mem[AW'(0)];
              r_cnt   <= HOLD_LD;
            end
          end
        end

        LD_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= LD_PULSE;
            r_next  <= 1'b1;
            r_cnt   <= PULSE_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        LD_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= LD_GAP;
            r_next  <= 1'b0;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        LD_GAP: begin
          if (r_cnt == '0) begin
            r_idx <= w_idx_nxt;
            if (w_idx_nxt < r_len) begin
              r_state <= LD_SETUP;
              r_data  <= r_mem[w_rd_addr_nxt];
              r_cnt   <= HOLD_LD;
            end else begin
              r_state <= FIN_PULSE;
              r_done  <= 1'b1;
              r_cnt   <= PULSE_LD;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        FIN_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= FIN_GAP;
            r_done  <= 1'b0;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        FIN_GAP: begin
          if (r_cnt == '0) begin
            r_state <= RUN_WAIT;
            r_cnt   <= STEP_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        RUN_WAIT: begin
          // Machine halt wins over any pending step.
          if (compute_done) begin
            r_state  <= HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
`ifdef TM_SEQ_STEP_LIMIT_EN
          end else if (r_steps == 16'(MAX_STEPS)) begin
            r_state   <= HALT;
            r_busy    <= 1'b0;
            r_halted  <= 1'b1;
            r_timeout <= 1'b1;
`endif
          end else if (auto_run) begin
            if (r_cnt == '0) begin
              r_state <= RUN_PULSE;
              r_next  <= 1'b1;
              r_steps <= w_steps_inc;
              r_cnt   <= PULSE_LD;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end else if (step_req) begin
            // step_req is only looked at here, so requests arriving in any
            // other state are simply lost rather than queued.
            r_state <= RUN_PULSE;
            r_next  <= 1'b1;
            r_steps <= w_steps_inc;
            r_cnt   <= PULSE_LD;
          end
        end

        RUN_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= RUN_GAP;
            r_next  <= 1'b0;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        RUN_GAP: begin
          if (r_cnt == '0) begin
            r_state <= RUN_WAIT;
            r_cnt   <= STEP_LD;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_next  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tm_sequencer
//
// Directed bench for tm_sequencer with a 4-word program store (so the length
// clamp can be exercised) and default timing parameters:
// HOLD=3, PULSE=2, GAP=2, STEP_INTERVAL=5. Each loaded word therefore takes
// 7 cycles (3 setup, 2 Next high, 2 low), the Done phase 4 cycles, and an
// auto-run step repeats every 9 cycles.
// -----------------------------------------------------------------------------
module tb_tm_sequencer;

  logic        clock;
  logic        Reset;
  logic        prog_we;
  logic [1:0]  prog_addr;
  logic [3:0]  prog_data;
  logic [2:0]  prog_len;
  logic        start;
  logic        auto_run;
  logic        step_req;
  logic        compute_done;
  logic [3:0]  tm_input_data;
  logic        tm_next;
  logic        tm_done;
  logic        busy;
  logic        halted;
  logic [15:0] step_count;
`ifdef TM_SEQ_STEP_LIMIT_EN
  logic        timeout;
  localparam int AUTO_STEPS = 6;
`else
  localparam int AUTO_STEPS = 10;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] words [4];

  tm_sequencer #(
    .PROG_DEPTH(4)
`ifdef TM_SEQ_STEP_LIMIT_EN
    ,
    .MAX_STEPS(8)
`endif
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_len(prog_len),
    .start(start),
    .auto_run(auto_run),
    .step_req(step_req),
    .compute_done(compute_done),
    .tm_input_data(tm_input_data),
    .tm_next(tm_next),
    .tm_done(tm_done),
    .busy(busy),
    .halted(halted),
    .step_count(step_count)
`ifdef TM_SEQ_STEP_LIMIT_EN
    ,
    .timeout(timeout)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  // After go() the bench sits one step past the edge that accepted start.
  task automatic go(input logic [2:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic do_halt();
    int n;
    compute_done = 1'b1;
    n = 0;
    while (!halted && n < 60) begin
      tick();
      n++;
    end
    compute_done = 1'b0;
    chk("halt_reach", {31'd0, halted}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [6:0] nb;
    logic [3:0] db;
    int         dok;
    int         first_done;
    int         nhi;
    int         t1;
    int         t2;
    logic       cd_set;

    words[0] = 4'd3; words[1] = 4'd1; words[2] = 4'd1; words[3] = 4'd2;
    Reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; auto_run = 1'b0; step_req = 1'b0;
    compute_done = 1'b0;

    // Reset before any clock edge.
    #1 Reset = 1'b1;
    #2;
    chk("rst_data", {28'd0, tm_input_data}, 32'd0);
    chk("rst_next", {31'd0, tm_next}, 32'd0);
    chk("rst_done", {31'd0, tm_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_steps", {16'd0, step_count}, 32'd0);
`ifdef TM_SEQ_STEP_LIMIT_EN
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
`endif
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Four-word load with manual stepping.
    for (int i = 0; i < 4; i++) wr(2'(i), words[i]);
    go(3'd4);
    for (int w = 0; w < 4; w++) begin
      nb = '0; dok = 0;
      for (int c = 0; c < 7; c++) begin
        nb[c] = tm_next;
        if (tm_input_data == words[w] && !tm_done) dok++;
        tick();
      end
      chk($sformatf("ld_next_w%0d", w), {25'd0, nb}, 32'b0011000);
      chk($sformatf("ld_data_w%0d", w), dok, 32'd7);
    end
    db = '0; nb = '0;
    for (int c = 0; c < 4; c++) begin
      db[c] = tm_done;
      nb[c] = tm_next;
      tick();
    end
    chk("fin_done", {28'd0, db}, 32'b0011);
    chk("fin_next", {25'd0, nb}, 32'd0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_steps0", {16'd0, step_count}, 32'd0);

    // Single step, then a request during the pulse that must be dropped.
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step1_next", {31'd0, tm_next}, 32'd1);
    chk("step1_cnt", {16'd0, step_count}, 32'd1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    repeat (8) tick();
    chk("drop_cnt", {16'd0, step_count}, 32'd1);
    chk("drop_next", {31'd0, tm_next}, 32'd0);

    // start and prog_we are ignored while running.
    prog_len = 3'd0; start = 1'b1;
    prog_we = 1'b1; prog_addr = 2'd0; prog_data = 4'hF;
    tick();
    start = 1'b0; prog_we = 1'b0;
    chk("busy_start_done", {31'd0, tm_done}, 32'd0);
    chk("busy_start_cnt", {16'd0, step_count}, 32'd1);

    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("step2_next", {31'd0, tm_next}, 32'd1);
    chk("step2_cnt", {16'd0, step_count}, 32'd2);
    do_halt();
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_cnt", {16'd0, step_count}, 32'd2);

    // Empty program.
    go(3'd0);
    db = '0; nb = '0;
    for (int c = 0; c < 4; c++) begin
      db[c] = tm_done;
      nb[c] = tm_next;
      tick();
    end
    chk("empty_done", {28'd0, db}, 32'b0011);
    chk("empty_next", {25'd0, nb}, 32'd0);
    chk("empty_halted", {31'd0, halted}, 32'd0);
    chk("empty_cnt", {16'd0, step_count}, 32'd0);
    step_req = 1'b1; tick(); step_req = 1'b0;
    chk("empty_wait_step", {16'd0, step_count}, 32'd1);
    do_halt();

    // Auto run until compute_done after AUTO_STEPS steps.
    auto_run = 1'b1;
    go(3'd0);
    t1 = -1; t2 = -1; cd_set = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (step_count == 16'd1 && t1 < 0) t1 = cyc;
      if (step_count == 16'd2 && t2 < 0) t2 = cyc;
      if (step_count == 16'(AUTO_STEPS) && !cd_set) begin
        compute_done = 1'b1;
        cd_set = 1'b1;
      end
      if (halted) break;
      tick();
    end
    compute_done = 1'b0;
    auto_run = 1'b0;
    chk("auto_first", t1, 32'd9);
    chk("auto_period", t2 - t1, 32'd9);
    chk("auto_cnt", {16'd0, step_count}, 32'(AUTO_STEPS));
    chk("auto_halted", {31'd0, halted}, 32'd1);
    chk("auto_busy", {31'd0, busy}, 32'd0);

    // The write attempted while busy must not have landed.
    go(3'd1);
    chk("busy_we_ignored", {28'd0, tm_input_data}, 32'd3);
    do_halt();

    // Length above the store depth is clamped to 4 words.
    go(3'd7);
    first_done = -1; nhi = 0;
    for (int c = 0; c < 40; c++) begin
      if (tm_next) nhi++;
      if (tm_done && first_done < 0) first_done = c;
      tick();
    end
    chk("clamp_next_hi", nhi, 32'd8);
    chk("clamp_done_at", first_done, 32'd28);
    do_halt();

    // Asynchronous reset in the middle of a load pulse.
    go(3'd4);
    tick(); tick(); tick();
    chk("pre_rst_next", {31'd0, tm_next}, 32'd1);
    #4 Reset = 1'b1;
    #1;
    chk("mid_rst_next", {31'd0, tm_next}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {28'd0, tm_input_data}, 32'd0);
    #1 Reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) wr(2'(i), words[i]);
    go(3'd4);
    chk("restart_w0", {28'd0, tm_input_data}, 32'd3);
    repeat (7) tick();
    chk("restart_w1", {28'd0, tm_input_data}, 32'd1);
    Reset = 1'b1; #1 Reset = 1'b0;
    tick();

`ifdef TM_SEQ_STEP_LIMIT_EN
    // Step limit with compute_done never asserted.
    auto_run = 1'b1;
    go(3'd0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (halted) break;
      tick();
    end
    auto_run = 1'b0;
    chk("lim_halted", {31'd0, halted}, 32'd1);
    chk("lim_timeout", {31'd0, timeout}, 32'd1);
    chk("lim_cnt", {16'd0, step_count}, 32'd8);
    go(3'd0);
    chk("lim_timeout_clr", {31'd0, timeout}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
